// File: rtl/alu_mc_pkg.sv
// Shared op codes, default width and FSM state type for the multi-cycle ALU.
package alu_mc_pkg;

  localparam int unsigned ALU_W = 32;

  localparam logic [5:0] ALU_OP_ADD = 6'h00;
  localparam logic [5:0] ALU_OP_SUB = 6'h01;
  localparam logic [5:0] ALU_OP_MUL = 6'h02;
  localparam logic [5:0] ALU_OP_OR  = 6'h03;
  localparam logic [5:0] ALU_OP_AND = 6'h04;
  localparam logic [5:0] ALU_OP_XOR = 6'h05;
  localparam logic [5:0] ALU_OP_SLL = 6'h06;
  localparam logic [5:0] ALU_OP_SRL = 6'h07;
  localparam logic [5:0] ALU_OP_LT  = 6'h09;
  localparam logic [5:0] ALU_OP_GT  = 6'h0A;
  localparam logic [5:0] ALU_OP_EQ  = 6'h0B;
  localparam logic [5:0] ALU_OP_MV  = 6'h0C;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DONE = 2'd2
  } alu_state_t;

endpackage

// File: rtl/alu_mc_mul_iter.sv
// Iterative shift-add unsigned multiplier: one partial product per clock,
// done is raised once all WIDTH multiplier bits have been consumed.
module mul_iter
  import alu_mc_pkg::*;
#(
  parameter int unsigned WIDTH = ALU_W
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               busy_q, busy_d;
  logic [WIDTH:0]     sum;

  // acc holds {hi, lo}; lo starts as the multiplier and is shifted out as hi fills
  always_comb begin
    mcand_d = mcand_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    sum     = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? mcand_q : '0)};
    done    = busy_q && (cnt_q == CNT_W'(WIDTH));
    if (start) begin
      mcand_d = a;
      acc_d   = {{WIDTH{1'b0}}, b};
      cnt_d   = '0;
      busy_d  = 1'b1;
    end else if (done) begin
      busy_d  = 1'b0;
    end else if (busy_q) begin
      acc_d   = {sum, acc_q[WIDTH-1:1]};
      cnt_d   = cnt_q + CNT_W'(1);
    end
  end

  assign product = acc_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      mcand_q <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      mcand_q <= mcand_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
    end
  end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU with valid/ready handshake: single-cycle ops register their
// result directly, MUL is delegated to mul_iter.
//
//   state   | meaning
//   IDLE    | no result held, ready for a request
//   MUL     | iterative multiply in progress, not ready
//   DONE    | result presented, held until out_ready
module alu_mc
  import alu_mc_pkg::*;
#(
  parameter int unsigned WIDTH = ALU_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [5:0]       op,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] w,
  output logic [WIDTH-1:0] w_hi,
  output logic             cmp,
  output logic             err
);

  alu_state_t         state_q, state_d;
  logic [WIDTH-1:0]   w_q, w_d, w_hi_q, w_hi_d;
  logic               cmp_q, cmp_d, err_q, err_d;
  logic               accept, mul_start, mul_done;
  logic [2*WIDTH-1:0] mul_prod;
  logic [WIDTH-1:0]   sc_w;
  logic               sc_cmp, sc_err, shift_oob;

  mul_iter #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .reset   (reset),
    .start   (mul_start),
    .a       (x),
    .b       (y),
    .done    (mul_done),
    .product (mul_prod)
  );

  always_comb begin
    sc_w      = '0;
    sc_cmp    = 1'b0;
    sc_err    = 1'b0;
    shift_oob = (y >= WIDTH'(WIDTH));
    case (op)
      ALU_OP_ADD: sc_w = x + y;
      ALU_OP_SUB: sc_w = x - y;
      ALU_OP_MUL: sc_w = '0;
      ALU_OP_OR:  sc_w = x | y;
      ALU_OP_AND: sc_w = x & y;
      ALU_OP_XOR: sc_w = x ^ y;
      ALU_OP_SLL: sc_w = shift_oob ? '0 : (x << y);
      ALU_OP_SRL: sc_w = shift_oob ? '0 : (x >> y);
      ALU_OP_LT:  sc_cmp = (x < y);
      ALU_OP_GT:  sc_cmp = (x > y);
      ALU_OP_EQ:  sc_cmp = (x == y);
      ALU_OP_MV:  sc_w = x;
      default:    sc_err = 1'b1;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    w_d       = w_q;
    w_hi_d    = w_hi_q;
    cmp_d     = cmp_q;
    err_d     = err_q;
    mul_start = 1'b0;
    in_ready  = 1'b0;
    case (state_q)
      ST_IDLE: in_ready = 1'b1;
      ST_MUL: begin
        if (mul_done) begin
          w_d     = mul_prod[WIDTH-1:0];
          w_hi_d  = mul_prod[2*WIDTH-1:WIDTH];
          cmp_d   = 1'b0;
          err_d   = 1'b0;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        in_ready = out_ready;
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    accept = in_valid && in_ready;
    // acceptance in DONE overrides the plain return to IDLE
    if (accept) begin
      if (op == ALU_OP_MUL) begin
        mul_start = 1'b1;
        state_d   = ST_MUL;
      end else begin
        w_d     = sc_w;
        w_hi_d  = '0;
        cmp_d   = sc_cmp;
        err_d   = sc_err;
        state_d = ST_DONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      w_q     <= '0;
      w_hi_q  <= '0;
      cmp_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      w_q     <= w_d;
      w_hi_q  <= w_hi_d;
      cmp_q   <= cmp_d;
      err_q   <= err_d;
    end
  end

  assign out_valid = (state_q == ST_DONE);
  assign w         = w_q;
  assign w_hi      = w_hi_q;
  assign cmp       = cmp_q;
  assign err       = err_q;

endmodule

// File: tb/tb_alu_mc.sv
// Directed bench for alu_mc: expected results queued at acceptance, checked
// by a monitor when each result transfers out.
module tb_alu_mc;
  import alu_mc_pkg::*;

  localparam int W = 32;

  typedef struct {
    logic [W-1:0] w;
    logic [W-1:0] w_hi;
    logic         cmp;
    logic         err;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b1;
  logic [5:0]   op = '0;
  logic [W-1:0] x = '0;
  logic [W-1:0] y = '0;
  logic         in_ready, out_valid, cmp, err;
  logic [W-1:0] w, w_hi;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  alu_mc #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .x         (x),
    .y         (y),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .w         (w),
    .w_hi      (w_hi),
    .cmp       (cmp),
    .err       (err)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic exp_t mk(logic [W-1:0] ew, logic [W-1:0] ehi, logic ec, logic ee);
    exp_t e;
    e.w = ew; e.w_hi = ehi; e.cmp = ec; e.err = ee;
    return e;
  endfunction

  // drive one request, push its expectation when it is accepted
  task automatic send(input logic [5:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                      input exp_t e, output int stall);
    bit acc;
    acc = 1'b0;
    stall = 0;
    in_valid = 1'b1; op = o; x = a; y = b;
    while (!acc && stall < 100) begin
      @(negedge clk);
      if (in_ready) acc = 1'b1;
      else stall++;
    end
    chk("accept", acc, 1);
    if (acc) sb.push_back(e);
    @(posedge clk); #1;
    in_valid = 1'b0;
    x = $urandom; y = $urandom;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (out_valid && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain", out_valid, 0);
  endtask

  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_output", 1, 0);
      end else begin
        mon_e = sb.pop_front();
        chk("w", w, mon_e.w);
        chk("w_hi", w_hi, mon_e.w_hi);
        chk("cmp", cmp, mon_e.cmp);
        chk("err", err, mon_e.err);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int st, k;
    bit bad, seen;
    logic [63:0] p;

    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_w", w, 0);
    chk("rst_w_hi", w_hi, 0);
    chk("rst_cmp", cmp, 0);
    chk("rst_err", err, 0);

    send(ALU_OP_ADD, 32'hFFFF_FFFF, 32'd1, mk(32'h0, 32'h0, 1'b0, 1'b0), st);
    chk("add_out_valid", out_valid, 1);
    send(ALU_OP_SUB, 32'h0, 32'd1, mk(32'hFFFF_FFFF, 32'h0, 1'b0, 1'b0), st);
    send(ALU_OP_OR,  32'hF0F0_0000, 32'h0000_0F0F, mk(32'hF0F0_0F0F, 32'h0, 1'b0, 1'b0), st);
    send(ALU_OP_AND, 32'hFF00_FF00, 32'h0FF0_0FF0, mk(32'h0F00_0F00, 32'h0, 1'b0, 1'b0), st);
    send(ALU_OP_XOR, 32'hFFFF_0000, 32'hFF00_FF00, mk(32'h00FF_FF00, 32'h0, 1'b0, 1'b0), st);
    send(ALU_OP_SRL, 32'h8000_0000, 32'd31, mk(32'h1, 32'h0, 1'b0, 1'b0), st);
    send(ALU_OP_SRL, 32'h8000_0000, 32'd32, mk(32'h0, 32'h0, 1'b0, 1'b0), st);
    send(ALU_OP_SLL, 32'h1, 32'd31, mk(32'h8000_0000, 32'h0, 1'b0, 1'b0), st);
    send(ALU_OP_SLL, 32'h1, 32'd32, mk(32'h0, 32'h0, 1'b0, 1'b0), st);
    wait_idle();

    // MUL latency and in_ready low while busy
    send(ALU_OP_MUL, 32'hFFFF_FFFF, 32'd2, mk(32'hFFFF_FFFE, 32'h1, 1'b0, 1'b0), st);
    chk("mul_in_ready_start", in_ready, 0);
    k = 0; bad = 1'b0;
    while (k < 100) begin
      @(posedge clk); #1;
      k++;
      if (out_valid) break;
      if (in_ready) bad = 1'b1;
    end
    chk("mul_latency", k, 33);
    chk("mul_in_ready_busy", bad, 0);
    send(ALU_OP_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, mk(32'h0000_0001, 32'hFFFF_FFFE, 1'b0, 1'b0), st);
    chk("mul_chain_stall", st, 0);
    p = 64'd12345 * 64'd6789;
    send(ALU_OP_MUL, 32'd12345, 32'd6789, mk(p[31:0], p[63:32], 1'b0, 1'b0), st);
    k = 0;
    while (!out_valid && k < 100) begin
      @(posedge clk); #1;
      k++;
    end
    wait_idle();

    // back-to-back relational ops
    send(ALU_OP_LT, 32'd3, 32'd5, mk(32'h0, 32'h0, 1'b1, 1'b0), st);
    send(ALU_OP_GT, 32'd3, 32'd5, mk(32'h0, 32'h0, 1'b0, 1'b0), st);
    chk("b2b_gt_stall", st, 0);
    send(ALU_OP_EQ, 32'd7, 32'd7, mk(32'h0, 32'h0, 1'b1, 1'b0), st);
    chk("b2b_eq_stall", st, 0);
    wait_idle();

    // backpressure on MV
    out_ready = 1'b0;
    send(ALU_OP_MV, 32'hA5, 32'h0, mk(32'hA5, 32'h0, 1'b0, 1'b0), st);
    bad = 1'b0;
    for (int i = 0; i < 4; i++) begin
      x = $urandom; y = $urandom; op = ALU_OP_ADD;
      @(posedge clk); #1;
      if (w !== 32'hA5 || in_ready !== 1'b0 || out_valid !== 1'b1) bad = 1'b1;
    end
    chk("bp_hold_w", w, 32'hA5);
    chk("bp_hold_any", bad, 0);
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_idle_valid", out_valid, 0);
    chk("bp_idle_ready", in_ready, 1);

    // unknown op then recovery
    send(6'h08, 32'h1234, 32'h5678, mk(32'h0, 32'h0, 1'b0, 1'b1), st);
    chk("unk_err", err, 1);
    send(ALU_OP_ADD, 32'd2, 32'd3, mk(32'd5, 32'h0, 1'b0, 1'b0), st);
    chk("add_err_clear", err, 0);
    wait_idle();

    // reset in the middle of a MUL
    send(ALU_OP_MUL, 32'd7, 32'd9, mk(32'd63, 32'h0, 1'b0, 1'b0), st);
    repeat (9) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    if (sb.size() > 0) void'(sb.pop_back());
    chk("abort_out_valid", out_valid, 0);
    chk("abort_in_ready", in_ready, 1);
    chk("abort_w", w, 0);
    chk("abort_w_hi", w_hi, 0);
    chk("abort_cmp", cmp, 0);
    chk("abort_err", err, 0);
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    chk("abort_never_presented", seen, 0);
    chk("scoreboard_empty", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
